// File: rtl/image_sequencer.sv
// image_sequencer: selects one of NUM_IMAGES images from next/prev buttons,
// a direct index load, and an optional timed slideshow.
// Slideshow logic is built only when IMAGE_SEQ_AUTOPLAY_EN is defined;
// without it the auto_en port is kept but ignored and no counter exists.
module image_sequencer #(
  parameter int NUM_IMAGES  = 4,
  parameter int SEL_W       = 4,
  parameter int WRAP        = 1,
  parameter int AUTO_PERIOD = 100000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             load,
  input  logic [SEL_W-1:0] load_idx,
  input  logic             auto_en,
  output logic [SEL_W-1:0] image_select,
  output logic             changed,
  output logic             at_last
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IMAGES - 1);
  localparam logic [SEL_W:0]   NUM_EXT  = (SEL_W + 1)'(NUM_IMAGES);

  logic             load_ok;
  logic             step_next;
  logic             step_prev;
  logic             manual_act;
  logic             auto_tick;
  logic [SEL_W-1:0] idx_inc;
  logic [SEL_W-1:0] idx_dec;
  logic [SEL_W-1:0] idx_d;

  // Decode requests; simultaneous next+prev cancel out.
  always_comb begin
    load_ok    = load && ({1'b0, load_idx} < NUM_EXT);
    step_next  = btn_next && !btn_prev;
    step_prev  = btn_prev && !btn_next;
    manual_act = load_ok || step_next || step_prev;
  end

  // Neighbour indices; end cases handled by compare so no carry/borrow
  // escapes SEL_W even when NUM_IMAGES fills the whole index range.
  always_comb begin
    if (image_select == LAST_IDX) begin
      idx_inc = (WRAP != 0) ? '0 : image_select;
    end else begin
      idx_inc = image_select + 1'b1;
    end
    if (image_select == '0) begin
      idx_dec = (WRAP != 0) ? LAST_IDX : image_select;
    end else begin
      idx_dec = image_select - 1'b1;
    end
  end

  // Priority: load, then buttons, then slideshow tick.
  always_comb begin
    idx_d = image_select;
    if (load_ok) begin
      idx_d = load_idx;
    end else if (step_next) begin
      idx_d = idx_inc;
    end else if (step_prev) begin
      idx_d = idx_dec;
    end else if (auto_tick) begin
      idx_d = idx_inc;
    end
  end

  // Index register; changed flags a real difference only.
  always_ff @(posedge clk) begin
    if (reset) begin
      image_select <= '0;
      changed      <= 1'b0;
    end else begin
      image_select <= idx_d;
      changed      <= (idx_d != image_select);
    end
  end

`ifdef IMAGE_SEQ_AUTOPLAY_EN
  localparam int CNT_W = $clog2(AUTO_PERIOD);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(AUTO_PERIOD - 1);

  logic [CNT_W-1:0] auto_cnt;

  assign auto_tick = auto_en && (auto_cnt == CNT_TC);

  // Slideshow period counter; any manual action restarts the full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_cnt <= '0;
    end else if (!auto_en || manual_act || (auto_cnt == CNT_TC)) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  logic unused_auto;

  assign auto_tick   = 1'b0;
  assign unused_auto = auto_en & manual_act & (AUTO_PERIOD >= 2);
`endif

  assign at_last = (image_select == LAST_IDX);

endmodule

// File: tb/tb_image_sequencer.sv
// Directed bench for image_sequencer: one wrapping and one saturating
// instance share the same stimulus; slideshow scenarios are compiled in
// only when IMAGE_SEQ_AUTOPLAY_EN is defined.
module tb_image_sequencer;

  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_next;
  logic             btn_prev;
  logic             load;
  logic [SEL_W-1:0] load_idx;
  logic             auto_en;

  logic [SEL_W-1:0] sel_w1, sel_w0;
  logic             chg_w1, chg_w0;
  logic             last_w1, last_w0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  image_sequencer #(.NUM_IMAGES(4), .SEL_W(SEL_W), .WRAP(1), .AUTO_PERIOD(5)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .load(load), .load_idx(load_idx), .auto_en(auto_en),
    .image_select(sel_w1), .changed(chg_w1), .at_last(last_w1)
  );

  image_sequencer #(.NUM_IMAGES(4), .SEL_W(SEL_W), .WRAP(0), .AUTO_PERIOD(5)) dut_sat (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .load(load), .load_idx(load_idx), .auto_en(auto_en),
    .image_select(sel_w0), .changed(chg_w0), .at_last(last_w0)
  );

  // One clock with the given request; returns at the following negedge.
  task automatic op(input logic n, input logic p, input logic l, input logic [SEL_W-1:0] li);
    @(negedge clk);
    btn_next = n; btn_prev = p; load = l; load_idx = li;
    @(negedge clk);
    btn_next = 1'b0; btn_prev = 1'b0; load = 1'b0; load_idx = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; load = 1'b0; load_idx = '0; auto_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel_w1); end
    checks++; if (chg_w1 !== 1'b0) begin errors++; $display("FAIL reset_changed got %b exp 0", chg_w1); end
    checks++; if (last_w1 !== 1'b0) begin errors++; $display("FAIL reset_at_last got %b exp 0", last_w1); end
    checks++; if (sel_w0 !== 4'd0) begin errors++; $display("FAIL reset_sel_sat got %0d exp 0", sel_w0); end
  endtask

  task automatic test_next_wrap();
    logic [SEL_W-1:0] exp_seq [5] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 1'b0, 1'b0, '0);
      if (chg_w1 === 1'b1) pulses++;
      checks++;
      if (sel_w1 !== exp_seq[i]) begin
        errors++; $display("FAIL next_wrap[%0d] got %0d exp %0d", i, sel_w1, exp_seq[i]);
      end
      checks++;
      if (last_w1 !== (exp_seq[i] == 4'd3)) begin
        errors++; $display("FAIL next_at_last[%0d] got %b exp %b", i, last_w1, exp_seq[i] == 4'd3);
      end
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL next_changed_count got %0d exp 5", pulses); end
    @(negedge clk);
    checks++; if (chg_w1 !== 1'b0) begin errors++; $display("FAIL changed_idle got %b exp 0", chg_w1); end
  endtask

  task automatic test_prev_wrap();
    op(1'b0, 1'b1, 1'b0, '0);
    checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL prev_1_to_0 got %0d exp 0", sel_w1); end
    op(1'b0, 1'b1, 1'b0, '0);
    checks++; if (sel_w1 !== 4'd3) begin errors++; $display("FAIL prev_wrap got %0d exp 3", sel_w1); end
    checks++; if (chg_w1 !== 1'b1) begin errors++; $display("FAIL prev_wrap_changed got %b exp 1", chg_w1); end
  endtask

  task automatic test_saturate();
    do_reset();
    op(1'b0, 1'b1, 1'b0, '0);
    checks++; if (sel_w0 !== 4'd0) begin errors++; $display("FAIL sat_prev got %0d exp 0", sel_w0); end
    checks++; if (chg_w0 !== 1'b0) begin errors++; $display("FAIL sat_prev_changed got %b exp 0", chg_w0); end
    op(1'b0, 1'b0, 1'b1, 4'd3);
    checks++; if (sel_w0 !== 4'd3) begin errors++; $display("FAIL sat_load3 got %0d exp 3", sel_w0); end
    op(1'b1, 1'b0, 1'b0, '0);
    checks++; if (sel_w0 !== 4'd3) begin errors++; $display("FAIL sat_next got %0d exp 3", sel_w0); end
    checks++; if (chg_w0 !== 1'b0) begin errors++; $display("FAIL sat_next_changed got %b exp 0", chg_w0); end
    checks++; if (last_w0 !== 1'b1) begin errors++; $display("FAIL sat_at_last got %b exp 1", last_w0); end
  endtask

  task automatic test_load_priority();
    do_reset();
    op(1'b1, 1'b0, 1'b1, 4'd2);
    checks++; if (sel_w1 !== 4'd2) begin errors++; $display("FAIL load_over_next got %0d exp 2", sel_w1); end
    checks++; if (chg_w1 !== 1'b1) begin errors++; $display("FAIL load_changed got %b exp 1", chg_w1); end
    op(1'b0, 1'b0, 1'b1, 4'd7);
    checks++; if (sel_w1 !== 4'd2) begin errors++; $display("FAIL load_oob got %0d exp 2", sel_w1); end
    checks++; if (chg_w1 !== 1'b0) begin errors++; $display("FAIL load_oob_changed got %b exp 0", chg_w1); end
    op(1'b0, 1'b1, 1'b1, 4'd7);
    checks++; if (sel_w1 !== 4'd1) begin errors++; $display("FAIL oob_load_then_prev got %0d exp 1", sel_w1); end
    op(1'b0, 1'b0, 1'b1, 4'd1);
    checks++; if (chg_w1 !== 1'b0) begin errors++; $display("FAIL load_same_changed got %b exp 0", chg_w1); end
  endtask

  task automatic test_both_buttons();
    op(1'b1, 1'b1, 1'b0, '0);
    checks++; if (sel_w1 !== 4'd1) begin errors++; $display("FAIL both_btn got %0d exp 1", sel_w1); end
    checks++; if (chg_w1 !== 1'b0) begin errors++; $display("FAIL both_btn_changed got %b exp 0", chg_w1); end
  endtask

  task automatic test_reset_override();
    @(negedge clk);
    reset = 1'b1; btn_next = 1'b1; load = 1'b1; load_idx = 4'd3;
    @(negedge clk);
    reset = 1'b0; btn_next = 1'b0; load = 1'b0; load_idx = '0;
    checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL reset_override got %0d exp 0", sel_w1); end
    checks++; if (chg_w1 !== 1'b0) begin errors++; $display("FAIL reset_override_changed got %b exp 0", chg_w1); end
  endtask

`ifdef IMAGE_SEQ_AUTOPLAY_EN
  task automatic test_autoplay();
    do_reset();
    auto_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL auto_wait[%0d] got %0d exp 0", i, sel_w1); end
    end
    @(negedge clk);
    checks++; if (sel_w1 !== 4'd1) begin errors++; $display("FAIL auto_adv1 got %0d exp 1", sel_w1); end
    checks++; if (chg_w1 !== 1'b1) begin errors++; $display("FAIL auto_adv1_changed got %b exp 1", chg_w1); end
    repeat (1) @(negedge clk);
    op(1'b1, 1'b0, 1'b0, '0);
    checks++; if (sel_w1 !== 4'd2) begin errors++; $display("FAIL auto_press got %0d exp 2", sel_w1); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (sel_w1 !== 4'd2) begin errors++; $display("FAIL auto_restart_wait[%0d] got %0d exp 2", i, sel_w1); end
    end
    @(negedge clk);
    checks++; if (sel_w1 !== 4'd3) begin errors++; $display("FAIL auto_after_press got %0d exp 3", sel_w1); end
    checks++; if (sel_w0 !== 4'd3) begin errors++; $display("FAIL auto_sat_reach got %0d exp 3", sel_w0); end
    repeat (5) @(negedge clk);
    checks++; if (sel_w0 !== 4'd3) begin errors++; $display("FAIL auto_sat_hold got %0d exp 3", sel_w0); end
    checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL auto_wrap got %0d exp 0", sel_w1); end
    auto_en = 1'b0;
  endtask

  task automatic test_auto_reset();
    op(1'b0, 1'b0, 1'b1, 4'd3);
    auto_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL auto_reset_sel got %0d exp 0", sel_w1); end
    checks++; if (chg_w1 !== 1'b0) begin errors++; $display("FAIL auto_reset_changed got %b exp 0", chg_w1); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL auto_reset_wait[%0d] got %0d exp 0", i, sel_w1); end
    end
    @(negedge clk);
    checks++; if (sel_w1 !== 4'd1) begin errors++; $display("FAIL auto_reset_adv got %0d exp 1", sel_w1); end
    auto_en = 1'b0;
  endtask
`endif

  task automatic test_auto_ignored();
`ifndef IMAGE_SEQ_AUTOPLAY_EN
    do_reset();
    auto_en = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (sel_w1 !== 4'd0) begin errors++; $display("FAIL auto_ignored got %0d exp 0", sel_w1); end
    auto_en = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_next_wrap();
    test_prev_wrap();
    test_saturate();
    test_load_priority();
    test_both_buttons();
    test_reset_override();
`ifdef IMAGE_SEQ_AUTOPLAY_EN
    test_autoplay();
    test_auto_reset();
`endif
    test_auto_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_sequencer.md
IMAGE_SEQUENCER -- requirements
Module: image_sequencer

Interface
REQ-001 SHALL have parameter NUM_IMAGES, default 4: number of selectable images, legal range 2..2**SEL_W.
REQ-002 SHALL have parameter SEL_W, default 4: width of index ports.
REQ-003 SHALL have parameter WRAP, default 1: 1 = wrap past ends, 0 = saturate at ends.
REQ-004 SHALL have parameter AUTO_PERIOD, default 100000000: clock cycles between slideshow advances, minimum 2.
REQ-005 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port btn_next  input  1  single-cycle pulse requesting the next image.
REQ-008 SHALL have port btn_prev  input  1  single-cycle pulse requesting the previous image.
REQ-009 SHALL have port load  input  1  single-cycle strobe for direct index load.
REQ-010 SHALL have port load_idx  input  SEL_W  index to load when load=1.
REQ-011 SHALL have port auto_en  input  1  level; enables slideshow mode.
REQ-012 SHALL have port image_select  output  SEL_W  current image index, registered.
REQ-013 SHALL have port changed  output  1  one-cycle pulse, high in the same cycle that image_select takes a new value.
REQ-014 SHALL have port at_last  output  1  high while image_select == NUM_IMAGES-1.

Function
REQ-015 SHALL update image_select on the clk edge that samples the request (1-cycle latency).
REQ-016 SHALL apply the following priority per cycle: load, then next/prev, then auto tick.
REQ-017 SHALL, on load with load_idx < NUM_IMAGES, set image_select = load_idx; load_idx >= NUM_IMAGES SHALL be ignored with no change.
REQ-018 SHALL treat btn_next and btn_prev both high in one cycle as no operation.
REQ-019 SHALL on next: index+1; at NUM_IMAGES-1 go to 0 if WRAP=1, else hold.
REQ-020 SHALL on prev: index-1; at 0 go to NUM_IMAGES-1 if WRAP=1, else hold.
REQ-021 SHALL assert changed only when the registered value actually differs (load of current index, saturated hold, or no-op SHALL give changed=0).
REQ-022 SHALL derive at_last combinationally from the registered image_select.
REQ-023 SHALL keep index arithmetic in SEL_W bits with no intermediate overflow for NUM_IMAGES = 2**SEL_W.

Reset
REQ-024 SHALL, when reset=1 at a clk edge, force image_select=0, changed=0, and auto counter=0, overriding all other inputs.
REQ-025 SHALL give at_last=0 after reset (1 only if NUM_IMAGES=1, which is illegal).
REQ-026 SHALL, on reset mid-slideshow, restart the full AUTO_PERIOD count after reset deasserts.

Configuration
REQ-027 SHALL implement slideshow only when macro IMAGE_SEQ_AUTOPLAY_EN is defined.
REQ-028 SHALL, with IMAGE_SEQ_AUTOPLAY_EN: run a counter 0..AUTO_PERIOD-1 while auto_en=1 and, at terminal count, issue an auto tick acting exactly as next (same wrap/saturate rules), then restart at 0.
REQ-029 SHALL, with IMAGE_SEQ_AUTOPLAY_EN, clear the counter whenever auto_en=0 or any accepted load/next/prev occurs, so a manual action restarts the full period.
REQ-030 SHALL, with IMAGE_SEQ_AUTOPLAY_EN and WRAP=0, stop auto-advancing at NUM_IMAGES-1 (hold, changed=0).
REQ-031 SHALL, without IMAGE_SEQ_AUTOPLAY_EN, keep the auto_en port, ignore it, and instantiate no counter.

Verification
REQ-032 SHALL cover: NUM_IMAGES=4, WRAP=1, 5 btn_next pulses -> image_select 1,2,3,0,1 with changed pulsed 5 times.
REQ-033 SHALL cover: WRAP=0, index 0, btn_prev -> stays 0, changed=0; index 3, btn_next -> stays 3, at_last=1.
REQ-034 SHALL cover: load=1 with load_idx=2 and btn_next=1 in the same cycle -> image_select=2; load_idx=7 (NUM_IMAGES=4) -> unchanged.
REQ-035 SHALL cover: btn_next and btn_prev both high at index 1 -> stays 1, changed=0.
REQ-036 SHALL cover: macro defined, AUTO_PERIOD=5, auto_en=1 -> advance every 5 cycles; btn_next at cycle 3 -> next auto advance 5 cycles after that press.
REQ-037 SHALL cover: reset=1 for one cycle at index 3 while auto_en=1 -> image_select=0, changed=0, and the first auto advance occurs AUTO_PERIOD cycles after release.
